// File: rtl/count_sequencer.sv
// count_sequencer: loadable up-counter with one-shot and wrap modes, pause (HOLD) and abort (stop).
// State encoding on the state port: IDLE=0, RUN=1, HOLD=2, DONE=3.
// Optional feature: define COUNT_PRESCALE_EN to advance the count only once every PRESCALE
// running cycles; without it the count advances on every running cycle and PRESCALE is unused.

module count_sequencer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             mode,
    output logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] limit_q;
    logic             mode_q;
    logic             done_q;
    logic             tick;
    logic             run_step;

    // A legal divider lies in 2..255; this named block only shows up when that is violated.
    if ((PRESCALE < 2) || (PRESCALE > 255)) begin : g_prescale_out_of_range
    end

    // A running cycle: the counter is active and not being held by pause.
    assign run_step = ((state_q == RUN) || (state_q == HOLD)) && !pause;

`ifdef COUNT_PRESCALE_EN
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_q;

    assign tick = (pre_q == PW'(PRESCALE - 1));

    // Prescaler counts running cycles; cleared while idle/done (so every run starts fresh), on stop and reset, frozen while paused.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else if (stop) begin
            pre_q <= '0;
        end else if ((state_q == IDLE) || (state_q == DONE)) begin
            pre_q <= '0;
        end else if (run_step) begin
            pre_q <= tick ? '0 : pre_q + PW'(1);
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Main sequencer: control priority is rst, then stop, then pause, then start/load_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                state_q <= IDLE;
                a_q     <= '0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (start) begin
                            state_q <= RUN;
                            limit_q <= limit;
                            mode_q  <= mode;
                            a_q     <= load_en ? load_val : '0;
                        end else if (load_en) begin
                            a_q <= load_val;
                        end
                    end
                    RUN, HOLD: begin
                        if (run_step) begin
                            state_q <= RUN;
                            if (tick) begin
                                if (a_q == limit_q) begin
                                    done_q <= 1'b1;
                                    if (mode_q) begin
                                        a_q <= '0;
                                    end else begin
                                        state_q <= DONE;
                                    end
                                end else begin
                                    a_q <= a_q + WIDTH'(1);
                                end
                            end
                        end else begin
                            state_q <= HOLD;
                            if ((state_q == HOLD) && load_en) begin
                                a_q <= load_val;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign a     = a_q;
    assign done  = done_q;
    assign state = state_q;
    assign busy  = (state_q == RUN) || (state_q == HOLD);

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed scenarios with hand-derived expectations, then randomized
// traffic checked against a behavioural model of the counter.
// With COUNT_PRESCALE_EN defined every count value is expected to last PRESCALE cycles.

module tb_count_sequencer;

    localparam int WIDTH = 4;
    localparam int PRE   = 3;
`ifdef COUNT_PRESCALE_EN
    localparam int T = PRE;
`else
    localparam int T = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             pause = 1'b0;
    logic             load_en = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic [WIDTH-1:0] limit = '0;
    logic             mode = 1'b0;
    logic [WIDTH-1:0] a;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: an active run is either counting or frozen; a finished one-shot parks in DONE.
    bit m_active = 0;
    bit m_frozen = 0;
    bit m_finished = 0;
    int m_a = 0;
    int m_limit = 0;
    bit m_mode = 0;
    bit m_done = 0;
    int m_run_cycles = 0;

    logic [7:0] exp_v;

    always #5 clk = ~clk;

    count_sequencer #(.WIDTH(WIDTH), .PRESCALE(PRE)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .load_en(load_en), .load_val(load_val), .limit(limit), .mode(mode),
        .a(a), .busy(busy), .done(done), .state(state)
    );

    // Expected {a, state, busy, done} from the model's view of the run.
    function automatic logic [7:0] model_outputs();
        logic [1:0] st;
        st = m_active ? (m_frozen ? 2'd2 : 2'd1) : (m_finished ? 2'd3 : 2'd0);
        return {4'(m_a), st, m_active, m_done};
    endfunction

    // Advance the model by one clock using the inputs that were presented at that edge.
    task model_step();
        m_done = 0;
        if (rst) begin
            m_active = 0; m_frozen = 0; m_finished = 0;
            m_a = 0; m_limit = 0; m_mode = 0; m_run_cycles = 0;
        end else if (stop) begin
            m_active = 0; m_frozen = 0; m_finished = 0;
            m_a = 0; m_run_cycles = 0;
        end else if (m_active) begin
            if (pause) begin
                if (m_frozen && load_en) m_a = int'(load_val);
                m_frozen = 1;
            end else begin
                m_frozen = 0;
                m_run_cycles++;
                if (m_run_cycles % T == 0) begin
                    if (m_a == m_limit) begin
                        m_done = 1;
                        if (m_mode) m_a = 0;
                        else begin m_active = 0; m_finished = 1; end
                    end else begin
                        m_a = (m_a + 1) % (1 << WIDTH);
                    end
                end
            end
        end else if (start) begin
            m_active = 1; m_frozen = 0; m_finished = 0;
            m_limit = int'(limit); m_mode = mode;
            m_a = load_en ? int'(load_val) : 0;
            m_run_cycles = 0;
        end else if (load_en) begin
            m_a = int'(load_val);
        end
    endtask

    // One clock: inputs already driven, outputs settle #1 after the edge.
    task applyStimulus();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task idle_inputs();
        rst = 0; start = 0; stop = 0; pause = 0; load_en = 0;
        load_val = '0; limit = '0; mode = 0;
    endtask

    task test_reset();
        idle_inputs();
        rst = 1; start = 1; load_en = 1; load_val = 4'd9; limit = 4'd5; mode = 1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            vectors++;
            if ({a, state, busy, done} !== 8'h00) begin
                miscompares++;
                $display("[TB] FAIL reset cycle %0d: got a/state/busy/done=%h expected %h", i, {a, state, busy, done}, 8'h00);
            end
        end
        idle_inputs();
        applyStimulus();
        vectors++;
        if ({a, state, busy, done} !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset release: got %h expected %h", {a, state, busy, done}, 8'h00);
        end
    endtask

    task test_one_shot();
        idle_inputs();
        start = 1; limit = 4'd5; mode = 0;
        applyStimulus();
        exp_v = {4'd0, 2'd1, 1'b1, 1'b0};
        vectors++;
        if ({a, state, busy, done} !== exp_v) begin
            miscompares++;
            $display("[TB] FAIL oneshot start: got %h expected %h", {a, state, busy, done}, exp_v);
        end
        start = 0; limit = 4'd2; mode = 1;
        for (int j = 1; j <= 6 * T + 1; j++) begin
            applyStimulus();
            if (j == 6 * T)     exp_v = {4'd5, 2'd3, 1'b0, 1'b1};
            else if (j > 6 * T) exp_v = {4'd5, 2'd3, 1'b0, 1'b0};
            else                exp_v = {4'(j / T), 2'd1, 1'b1, 1'b0};
            vectors++;
            if ({a, state, busy, done} !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL oneshot edge %0d: got %h expected %h", j, {a, state, busy, done}, exp_v);
            end
        end
    endtask

    task test_wrap();
        idle_inputs();
        start = 1; limit = 4'd15; mode = 1;
        applyStimulus();
        start = 0; limit = 4'd3; mode = 0;
        for (int j = 1; j <= 40 * T; j++) begin
            start = (j >= 20 && j < 23);
            applyStimulus();
            exp_v = {4'((j / T) % 16), 2'd1, 1'b1, (j % (16 * T) == 0)};
            vectors++;
            if ({a, state, busy, done} !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL wrap edge %0d: got %h expected %h", j, {a, state, busy, done}, exp_v);
            end
        end
        start = 0; stop = 1;
        applyStimulus();
        vectors++;
        if ({a, state, busy, done} !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL wrap stop: got %h expected %h", {a, state, busy, done}, 8'h00);
        end
        stop = 0;
    endtask

    task test_pause();
        int r;
        idle_inputs();
        start = 1; limit = 4'd9; mode = 0;
        applyStimulus();
        start = 0;
        for (int j = 1; j <= 10 * T + 4; j++) begin
            pause = (j > 3 * T) && (j <= 3 * T + 3);
            applyStimulus();
            r = (j <= 3 * T) ? j : j - 3;
            if (pause)           exp_v = {4'd3, 2'd2, 1'b1, 1'b0};
            else if (r == 10 * T) exp_v = {4'd9, 2'd3, 1'b0, 1'b1};
            else if (r > 10 * T)  exp_v = {4'd9, 2'd3, 1'b0, 1'b0};
            else                  exp_v = {4'(r / T), 2'd1, 1'b1, 1'b0};
            vectors++;
            if ({a, state, busy, done} !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL pause edge %0d: got %h expected %h", j, {a, state, busy, done}, exp_v);
            end
        end
        pause = 0;
    endtask

    task test_stop();
        for (int k = 0; k < 2; k++) begin
            idle_inputs();
            start = 1; limit = 4'd12; mode = 0;
            applyStimulus();
            start = 0;
            for (int j = 0; j < 7 * T; j++) applyStimulus();
            exp_v = {4'd7, 2'd1, 1'b1, 1'b0};
            vectors++;
            if ({a, state, busy, done} !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL abort %0d reach 7: got %h expected %h", k, {a, state, busy, done}, exp_v);
            end
            if (k == 0) stop = 1; else rst = 1;
            applyStimulus();
            vectors++;
            if ({a, state, busy, done} !== 8'h00) begin
                miscompares++;
                $display("[TB] FAIL abort %0d: got %h expected %h", k, {a, state, busy, done}, 8'h00);
            end
            stop = 0; rst = 0;
            applyStimulus();
            vectors++;
            if ({a, state, busy, done} !== 8'h00) begin
                miscompares++;
                $display("[TB] FAIL abort %0d after: got %h expected %h", k, {a, state, busy, done}, 8'h00);
            end
        end
    endtask

    task test_load();
        idle_inputs();
        load_en = 1; load_val = 4'd6;
        applyStimulus();
        exp_v = {4'd6, 2'd0, 1'b0, 1'b0};
        vectors++;
        if ({a, state, busy, done} !== exp_v) begin
            miscompares++;
            $display("[TB] FAIL idle load: got %h expected %h", {a, state, busy, done}, exp_v);
        end
        start = 1; load_val = 4'd9; limit = 4'd11; mode = 0;
        applyStimulus();
        start = 0; load_en = 0;
        for (int j = 1; j <= 3 * T; j++) begin
            applyStimulus();
            exp_v = (j == 3 * T) ? {4'd11, 2'd3, 1'b0, 1'b1} : {4'(9 + j / T), 2'd1, 1'b1, 1'b0};
            vectors++;
            if ({a, state, busy, done} !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL load run edge %0d: got %h expected %h", j, {a, state, busy, done}, exp_v);
            end
        end
        start = 1; load_en = 1; load_val = 4'd14; limit = 4'd1;
        applyStimulus();
        start = 0; load_en = 0;
        for (int j = 1; j <= 4 * T; j++) begin
            applyStimulus();
            exp_v = (j == 4 * T) ? {4'd1, 2'd3, 1'b0, 1'b1} : {4'((14 + j / T) % 16), 2'd1, 1'b1, 1'b0};
            vectors++;
            if ({a, state, busy, done} !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL load wrap edge %0d: got %h expected %h", j, {a, state, busy, done}, exp_v);
            end
        end
        start = 1; limit = 4'd0;
        applyStimulus();
        start = 0;
        for (int j = 1; j <= T; j++) begin
            applyStimulus();
            exp_v = (j == T) ? {4'd0, 2'd3, 1'b0, 1'b1} : {4'd0, 2'd1, 1'b1, 1'b0};
            vectors++;
            if ({a, state, busy, done} !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL limit zero edge %0d: got %h expected %h", j, {a, state, busy, done}, exp_v);
            end
        end
    endtask

    task test_random();
        for (int n = 0; n < 1500; n++) begin
            rst      = ($urandom % 80 == 0);
            stop     = ($urandom % 40 == 0);
            pause    = ($urandom % 4 == 0);
            start    = ($urandom % 6 == 0);
            mode     = $urandom % 2;
            limit    = ($urandom % 4 == 0) ? 4'($urandom % 3) : 4'($urandom % 16);
            load_val = 4'($urandom % 16);
            load_en  = ($urandom % 5 == 0) && (!m_active || (m_frozen && pause));
            applyStimulus();
            exp_v = model_outputs();
            vectors++;
            if ({a, state, busy, done} !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL random step %0d: got %h expected %h", n, {a, state, busy, done}, exp_v);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_wrap();
        test_pause();
        test_stop();
        test_load();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
